// File: rtl/dbg_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbg_mem_arbiter_if                                              |
// | Purpose  : Single-word memory request/response bus shared by the core,     |
// |            debug master and physical-memory sides of dbg_mem_arbiter.      |
// | Signals  : stb/we/mbe/address/wdata flow master->slave,                    |
// |            rdata/resp flow slave->master.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface dbg_mem_arbiter_if #(
  parameter int S_OFFSET = 2,
  parameter int ADDR_W   = 32
);
  localparam int S_MASK = 2 ** S_OFFSET;
  localparam int S_LINE = 8 * S_MASK;

  logic              stb;
  logic              we;
  logic [S_MASK-1:0] mbe;
  logic [ADDR_W-1:0] address;
  logic [S_LINE-1:0] wdata;
  logic [S_LINE-1:0] rdata;
  logic              resp;

  // Requester side: issues the access and receives the completion.
  modport master (
    output stb, we, mbe, address, wdata,
    input  rdata, resp
  );

  // Responder side: accepts the access and returns the completion.
  modport slave (
    input  stb, we, mbe, address, wdata,
    output rdata, resp
  );
endinterface
`default_nettype wire

// File: rtl/dbg_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbg_mem_arbiter                                                 |
// | Purpose  : Merges the core data port and the debug-module master port onto |
// |            one physical-memory port, one transaction at a time. Ties are   |
// |            round-robin, or always won by debug when DBG_PRIORITY=1. All    |
// |            memory-side request outputs come straight from registers.       |
// | Ports    : clk_i     - clock                                               |
// |            rst_ni    - synchronous active-low reset                        |
// |            cpu       - core requester (slave modport)                      |
// |            dmm       - debug requester (slave modport)                     |
// |            pmem      - physical memory (master modport)                    |
// |            dbg_owner - high while a debug access owns the memory port      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dbg_mem_arbiter #(
  parameter int S_OFFSET     = 2,
  parameter int ADDR_W       = 32,
  parameter bit DBG_PRIORITY = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dbg_mem_arbiter_if.slave  cpu,
  dbg_mem_arbiter_if.slave  dmm,
  dbg_mem_arbiter_if.master pmem,
  output logic              dbg_owner
);
  localparam int S_MASK = 2 ** S_OFFSET;
  localparam int S_LINE = 8 * S_MASK;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [S_MASK-1:0] mbe_q, mbe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [S_LINE-1:0] wdata_q, wdata_d;

  logic              pick_dbg;
  logic              busy;
  logic              cpu_sel;
  logic              dbg_sel;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_CPU;
      last_q  <= GRANT_CPU;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      mbe_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      mbe_q   <= mbe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    stb_d    = stb_q;
    we_d     = we_q;
    mbe_d    = mbe_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pick_dbg = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu.stb || dmm.stb) begin
          // On a tie debug wins if it has priority, or if the core was
          // served last; otherwise the lone requester wins.
          if (cpu.stb && dmm.stb) begin
            pick_dbg = DBG_PRIORITY || (last_q == GRANT_CPU);
          end else begin
            pick_dbg = dmm.stb;
          end
          grant_d = pick_dbg ? GRANT_DBG : GRANT_CPU;
          stb_d   = 1'b1;
          we_d    = pick_dbg ? dmm.we      : cpu.we;
          mbe_d   = pick_dbg ? dmm.mbe     : cpu.mbe;
          addr_d  = pick_dbg ? dmm.address : cpu.address;
          wdata_d = pick_dbg ? dmm.wdata   : cpu.wdata;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Request fields stay frozen; only the memory completion matters.
        if (pmem.resp) begin
          stb_d   = 1'b0;
          last_d  = grant_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Turnaround cycle lets the finished requester release its strobe
        // before the next arbitration.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == ST_BUSY);
  assign cpu_sel = busy && (grant_q == GRANT_CPU);
  assign dbg_sel = busy && (grant_q == GRANT_DBG);

  assign pmem.stb     = stb_q;
  assign pmem.we      = we_q;
  assign pmem.mbe     = mbe_q;
  assign pmem.address = addr_q;
  assign pmem.wdata   = wdata_q;

  // Completion is forwarded only to the current owner; late or stray
  // memory responses outside BUSY are dropped.
  assign cpu.resp  = pmem.resp && cpu_sel;
  assign dmm.resp  = pmem.resp && dbg_sel;
  assign cpu.rdata = cpu_sel ? pmem.rdata : '0;
  assign dmm.rdata = dbg_sel ? pmem.rdata : '0;

  assign dbg_owner = dbg_sel;
endmodule
`default_nettype wire

// File: tb/tb_dbg_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dbg_mem_arbiter                                              |
// | Purpose  : Self-checking bench for dbg_mem_arbiter. One round-robin and    |
// |            one debug-priority instance, each with its own bus interfaces.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dbg_mem_arbiter;
  localparam int S_OFFSET = 2;
  localparam int ADDR_W   = 32;

  logic clk;
  logic rst_n;
  logic rr_owner;
  logic pr_owner;

  int n_checks;
  int n_fail;
  bit m_last_dbg;  // reference model: who was served last (1 = debug)

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dbg_mem_arbiter_if #(.S_OFFSET(S_OFFSET), .ADDR_W(ADDR_W)) rr_cpu ();
  dbg_mem_arbiter_if #(.S_OFFSET(S_OFFSET), .ADDR_W(ADDR_W)) rr_dmm ();
  dbg_mem_arbiter_if #(.S_OFFSET(S_OFFSET), .ADDR_W(ADDR_W)) rr_mem ();
  dbg_mem_arbiter_if #(.S_OFFSET(S_OFFSET), .ADDR_W(ADDR_W)) pr_cpu ();
  dbg_mem_arbiter_if #(.S_OFFSET(S_OFFSET), .ADDR_W(ADDR_W)) pr_dmm ();
  dbg_mem_arbiter_if #(.S_OFFSET(S_OFFSET), .ADDR_W(ADDR_W)) pr_mem ();

  dbg_mem_arbiter #(.S_OFFSET(S_OFFSET), .ADDR_W(ADDR_W), .DBG_PRIORITY(1'b0)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .cpu(rr_cpu), .dmm(rr_dmm), .pmem(rr_mem), .dbg_owner(rr_owner)
  );

  dbg_mem_arbiter #(.S_OFFSET(S_OFFSET), .ADDR_W(ADDR_W), .DBG_PRIORITY(1'b1)) u_pr (
    .clk_i(clk), .rst_ni(rst_n), .cpu(pr_cpu), .dmm(pr_dmm), .pmem(pr_mem), .dbg_owner(pr_owner)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the round-robin instance, starting in IDLE with
  // requests already presented and ending back in IDLE.
  task automatic run_rr(input int lat, input logic [31:0] rd, input bit mutate, output bit served_dbg);
    bit          exp_dbg;
    logic        exp_we;
    logic [3:0]  exp_mbe;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    if (rr_cpu.stb && rr_dmm.stb) exp_dbg = !m_last_dbg;
    else                          exp_dbg = rr_dmm.stb;
    exp_we   = exp_dbg ? rr_dmm.we      : rr_cpu.we;
    exp_mbe  = exp_dbg ? rr_dmm.mbe     : rr_cpu.mbe;
    exp_addr = exp_dbg ? rr_dmm.address : rr_cpu.address;
    exp_wd   = exp_dbg ? rr_dmm.wdata   : rr_cpu.wdata;
    step();
    n_checks++; if (rr_mem.stb !== 1'b1) begin n_fail++; $display("FAIL grant_stb: got %b want 1", rr_mem.stb); end
    n_checks++; if (rr_owner !== exp_dbg) begin n_fail++; $display("FAIL grant_owner: got %b want %b", rr_owner, exp_dbg); end
    n_checks++; if ({rr_mem.we, rr_mem.mbe, rr_mem.address, rr_mem.wdata} !== {exp_we, exp_mbe, exp_addr, exp_wd}) begin
      n_fail++; $display("FAIL grant_fields: got we=%b mbe=%h a=%h wd=%h want we=%b mbe=%h a=%h wd=%h",
        rr_mem.we, rr_mem.mbe, rr_mem.address, rr_mem.wdata, exp_we, exp_mbe, exp_addr, exp_wd);
    end
    for (int i = 0; i < lat; i++) begin
      if (mutate) begin
        rr_cpu.we = 1'($urandom); rr_cpu.mbe = 4'($urandom); rr_cpu.address = $urandom; rr_cpu.wdata = $urandom;
        rr_dmm.we = 1'($urandom); rr_dmm.mbe = 4'($urandom); rr_dmm.address = $urandom; rr_dmm.wdata = $urandom;
        if (i == 0) begin
          if (exp_dbg) rr_dmm.stb = 1'b0; else rr_cpu.stb = 1'b0;
        end
      end
      step();
      n_checks++; if ({rr_mem.stb, rr_mem.we, rr_mem.mbe, rr_mem.address, rr_mem.wdata} !== {1'b1, exp_we, exp_mbe, exp_addr, exp_wd}) begin
        n_fail++; $display("FAIL busy_hold: got a=%h wd=%h stb=%b want a=%h wd=%h stb=1", rr_mem.address, rr_mem.wdata, rr_mem.stb, exp_addr, exp_wd);
      end
      n_checks++; if ({rr_cpu.resp, rr_dmm.resp} !== 2'b00) begin n_fail++; $display("FAIL busy_noresp: got %b%b want 00", rr_cpu.resp, rr_dmm.resp); end
    end
    rr_mem.rdata = rd;
    rr_mem.resp  = 1'b1;
    #1;
    n_checks++; if ({rr_cpu.resp, rr_dmm.resp} !== {!exp_dbg, exp_dbg}) begin
      n_fail++; $display("FAIL resp_route: got cpu=%b dmm=%b want cpu=%b dmm=%b", rr_cpu.resp, rr_dmm.resp, !exp_dbg, exp_dbg);
    end
    n_checks++; if ((exp_dbg ? rr_dmm.rdata : rr_cpu.rdata) !== rd) begin
      n_fail++; $display("FAIL rdata_owner: got %h want %h", exp_dbg ? rr_dmm.rdata : rr_cpu.rdata, rd);
    end
    n_checks++; if ((exp_dbg ? rr_cpu.rdata : rr_dmm.rdata) !== 32'h0) begin
      n_fail++; $display("FAIL rdata_loser: got %h want 0", exp_dbg ? rr_cpu.rdata : rr_dmm.rdata);
    end
    step();
    rr_mem.resp  = 1'b0;
    rr_mem.rdata = $urandom;
    #1;
    n_checks++; if ({rr_mem.stb, rr_cpu.resp, rr_dmm.resp, rr_owner} !== 4'b0000) begin
      n_fail++; $display("FAIL done_idle: got stb=%b cresp=%b dresp=%b own=%b want 0000", rr_mem.stb, rr_cpu.resp, rr_dmm.resp, rr_owner);
    end
    m_last_dbg = exp_dbg;
    served_dbg = exp_dbg;
    step();
  endtask

  task automatic test_reset();
    bit s;
    rst_n = 1'b0;
    rr_cpu.stb = 1'b1; rr_dmm.stb = 1'b1; pr_cpu.stb = 1'b1; pr_dmm.stb = 1'b1;
    rr_cpu.address = 32'h0000_0040; rr_dmm.address = 32'h0000_0044;
    rr_cpu.wdata = 32'hAAAA_0001; rr_dmm.wdata = 32'hBBBB_0002;
    rr_cpu.mbe = 4'hF; rr_dmm.mbe = 4'hF; rr_cpu.we = 1'b1; rr_dmm.we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if ({rr_mem.stb, rr_mem.we, rr_mem.mbe, rr_mem.address, rr_mem.wdata} !== '0) begin
        n_fail++; $display("FAIL reset_pmem_rr: got stb=%b a=%h wd=%h want all 0", rr_mem.stb, rr_mem.address, rr_mem.wdata);
      end
      n_checks++; if ({rr_cpu.resp, rr_dmm.resp, rr_owner, pr_mem.stb, pr_cpu.resp, pr_dmm.resp, pr_owner} !== 7'b0) begin
        n_fail++; $display("FAIL reset_outputs: got %b%b%b%b%b%b%b want 0000000",
          rr_cpu.resp, rr_dmm.resp, rr_owner, pr_mem.stb, pr_cpu.resp, pr_dmm.resp, pr_owner);
      end
    end
    rst_n = 1'b1;
    pr_cpu.stb = 1'b0; pr_dmm.stb = 1'b0;
    m_last_dbg = 1'b0;
    run_rr(1, 32'h0BAD_F00D, 1'b0, s);
    rr_cpu.stb = 1'b0; rr_dmm.stb = 1'b0;
  endtask

  task automatic test_single_read();
    bit s;
    rr_cpu.stb = 1'b1; rr_cpu.we = 1'b0; rr_cpu.mbe = 4'hF;
    rr_cpu.address = 32'h0000_0100; rr_cpu.wdata = 32'h0;
    run_rr(2, 32'hDEAD_BEEF, 1'b0, s);
    rr_cpu.stb = 1'b0;
  endtask

  task automatic test_tie_rr();
    bit s;
    rr_cpu.stb = 1'b1; rr_dmm.stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rr_cpu.address = 32'h1000 + 32'(k); rr_dmm.address = 32'h2000 + 32'(k);
      rr_cpu.wdata = $urandom; rr_dmm.wdata = $urandom;
      run_rr($urandom_range(0, 3), $urandom, 1'b0, s);
    end
    rr_cpu.stb = 1'b0; rr_dmm.stb = 1'b0;
  endtask

  task automatic test_dbg_priority();
    bit          e;
    logic [31:0] rd;
    pr_cpu.stb = 1'b1; pr_cpu.we = 1'b0; pr_cpu.mbe = 4'hF; pr_cpu.address = 32'h200; pr_cpu.wdata = 32'h0;
    pr_dmm.stb = 1'b1; pr_dmm.we = 1'b0; pr_dmm.mbe = 4'hF; pr_dmm.address = 32'h300; pr_dmm.wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) pr_dmm.stb = 1'b0;
      e  = pr_dmm.stb;  // debug wins whenever it is requesting
      rd = $urandom;
      step();
      n_checks++; if (pr_owner !== e) begin n_fail++; $display("FAIL prio_owner[%0d]: got %b want %b", k, pr_owner, e); end
      n_checks++; if (pr_mem.address !== (e ? 32'h300 : 32'h200)) begin
        n_fail++; $display("FAIL prio_addr[%0d]: got %h want %h", k, pr_mem.address, e ? 32'h300 : 32'h200);
      end
      pr_mem.rdata = rd; pr_mem.resp = 1'b1;
      #1;
      n_checks++; if ({pr_cpu.resp, pr_dmm.resp} !== {!e, e}) begin
        n_fail++; $display("FAIL prio_resp[%0d]: got cpu=%b dmm=%b want cpu=%b dmm=%b", k, pr_cpu.resp, pr_dmm.resp, !e, e);
      end
      n_checks++; if ((e ? pr_dmm.rdata : pr_cpu.rdata) !== rd) begin
        n_fail++; $display("FAIL prio_rdata[%0d]: got %h want %h", k, e ? pr_dmm.rdata : pr_cpu.rdata, rd);
      end
      step();
      pr_mem.resp = 1'b0;
      step();
    end
    pr_cpu.stb = 1'b0;
  endtask

  task automatic test_dbg_write();
    bit s;
    rr_cpu.stb = 1'b1; rr_cpu.we = 1'b0; rr_cpu.mbe = 4'hF; rr_cpu.address = 32'h0000_0500; rr_cpu.wdata = 32'h0;
    rr_dmm.stb = 1'b1; rr_dmm.we = 1'b1; rr_dmm.mbe = 4'b0011;
    rr_dmm.address = 32'h8000_0000; rr_dmm.wdata = 32'h1234_5678;
    run_rr(3, $urandom, 1'b1, s);
    rr_dmm.stb = 1'b0;
    rr_cpu.stb = 1'b1;
    run_rr(1, $urandom, 1'b0, s);
    rr_cpu.stb = 1'b0;
  endtask

  task automatic test_stray_and_reset();
    bit s;
    rr_mem.resp = 1'b1; rr_mem.rdata = 32'hFFFF_FFFF;
    #1;
    n_checks++; if ({rr_cpu.resp, rr_dmm.resp} !== 2'b00) begin n_fail++; $display("FAIL stray_resp: got %b%b want 00", rr_cpu.resp, rr_dmm.resp); end
    step();
    n_checks++; if ({rr_mem.stb, rr_cpu.resp, rr_dmm.resp} !== 3'b000) begin
      n_fail++; $display("FAIL stray_idle: got stb=%b resp=%b%b want 000", rr_mem.stb, rr_cpu.resp, rr_dmm.resp);
    end
    rr_mem.resp = 1'b0;
    rr_cpu.stb = 1'b1; rr_cpu.address = 32'h0000_0C00;
    step();
    n_checks++; if (rr_mem.stb !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", rr_mem.stb); end
    rst_n = 1'b0;
    step();
    n_checks++; if ({rr_mem.stb, rr_mem.address} !== 33'h0) begin
      n_fail++; $display("FAIL midbusy_reset: got stb=%b a=%h want 0 0", rr_mem.stb, rr_mem.address);
    end
    rr_mem.resp = 1'b1;
    #1;
    n_checks++; if ({rr_cpu.resp, rr_dmm.resp} !== 2'b00) begin n_fail++; $display("FAIL reset_noresp: got %b%b want 00", rr_cpu.resp, rr_dmm.resp); end
    rr_mem.resp = 1'b0; rr_cpu.stb = 1'b0; rst_n = 1'b1;
    m_last_dbg = 1'b0;
    step();
    rr_cpu.stb = 1'b1; rr_dmm.stb = 1'b1;
    rr_dmm.address = 32'h0000_0D00;
    run_rr(0, $urandom, 1'b0, s);
    rr_cpu.stb = 1'b0; rr_dmm.stb = 1'b0;
  endtask

  task automatic test_random();
    bit pc;
    bit pd;
    bit s;
    pc = 1'b0; pd = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (!pc && $urandom_range(0, 1) == 1) begin
        pc = 1'b1; rr_cpu.stb = 1'b1; rr_cpu.we = 1'($urandom);
        rr_cpu.mbe = 4'($urandom); rr_cpu.address = $urandom; rr_cpu.wdata = $urandom;
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1'b1; rr_dmm.stb = 1'b1; rr_dmm.we = 1'($urandom);
        rr_dmm.mbe = 4'($urandom); rr_dmm.address = $urandom; rr_dmm.wdata = $urandom;
      end
      if (!pc && !pd) begin
        step();
        n_checks++; if ({rr_mem.stb, rr_owner} !== 2'b00) begin n_fail++; $display("FAIL rand_idle: got stb=%b own=%b want 00", rr_mem.stb, rr_owner); end
      end else begin
        run_rr($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), s);
        if (s) begin pd = 1'b0; rr_dmm.stb = 1'b0; end
        else   begin pc = 1'b0; rr_cpu.stb = 1'b0; end
      end
    end
    rr_cpu.stb = 1'b0; rr_dmm.stb = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_last_dbg = 1'b0;
    rst_n = 1'b0;
    rr_cpu.stb = 1'b0; rr_cpu.we = 1'b0; rr_cpu.mbe = '0; rr_cpu.address = '0; rr_cpu.wdata = '0;
    rr_dmm.stb = 1'b0; rr_dmm.we = 1'b0; rr_dmm.mbe = '0; rr_dmm.address = '0; rr_dmm.wdata = '0;
    pr_cpu.stb = 1'b0; pr_cpu.we = 1'b0; pr_cpu.mbe = '0; pr_cpu.address = '0; pr_cpu.wdata = '0;
    pr_dmm.stb = 1'b0; pr_dmm.we = 1'b0; pr_dmm.mbe = '0; pr_dmm.address = '0; pr_dmm.wdata = '0;
    rr_mem.resp = 1'b0; rr_mem.rdata = '0;
    pr_mem.resp = 1'b0; pr_mem.rdata = '0;
    test_reset();
    test_single_read();
    test_tie_rr();
    test_dbg_priority();
    test_dbg_write();
    test_stray_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
